// File: rtl/app_line_pkg.sv
// app_line_pkg
//   Shared definitions for the OUT-endpoint line buffer: the fill/drain state
//   encoding, the default line terminator and the backspace byte values used
//   when the optional backspace editing (LINE_BUF_BS_EN) is compiled in.
//   No ports.
package app_line_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } line_state_t;

  localparam logic [7:0] TERM_CHAR_DEF = 8'h0D;
  localparam logic [7:0] BS_CHAR       = 8'h08;
  localparam logic [7:0] DEL_CHAR      = 8'h7F;

endpackage

// File: rtl/line_buf_mem.sv
// line_buf_mem
//   DEPTH x DATA_W register file holding one line. Synchronous write,
//   asynchronous (combinational) read, no reset on the storage.
// Ports:
//   clk_i    in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
module line_buf_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/app_out_line_buf.sv
// app_out_line_buf
//   Collects bytes from the bulk OUT endpoint application stream into a
//   single line buffer. A line closes on TERM_CHAR (stored as the last byte),
//   when the buffer fills, or on flush_i. The closed line is then replayed as
//   a framed byte stream with length, last and truncation markers. Fill and
//   drain never overlap; while draining, the endpoint side is backpressured.
// Optional feature:
//   LINE_BUF_BS_EN - when defined, 8'h08/8'h7F erase the previous byte of the
//   line instead of being stored.
// Ports:
//   clk_i            in   clock
//   rstn_i           in   asynchronous active-low reset
//   app_out_data_i   in   byte from endpoint
//   app_out_valid_i  in   byte valid
//   app_out_ready_o  out  byte accepted when valid & ready
//   flush_i          in   close a partial line (ignored while draining)
//   line_data_o      out  current line byte
//   line_valid_o     out  line byte valid
//   line_ready_i     in   consumer accepts byte when valid & ready
//   line_last_o      out  current byte is the last of the line
//   line_len_o       out  byte count of the line being drained
//   line_trunc_o     out  line was closed by a full buffer, no terminator
module app_out_line_buf
  import app_line_pkg::*;
#(
  parameter int         LINE_MAXLEN = 64,
  parameter logic [7:0] TERM_CHAR   = TERM_CHAR_DEF,
  parameter int         LEN_W       = $clog2(LINE_MAXLEN + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [7:0]       app_out_data_i,
  input  logic             app_out_valid_i,
  output logic             app_out_ready_o,
  input  logic             flush_i,
  output logic [7:0]       line_data_o,
  output logic             line_valid_o,
  input  logic             line_ready_i,
  output logic             line_last_o,
  output logic [LEN_W-1:0] line_len_o,
  output logic             line_trunc_o
);

  localparam int              IDX_W    = $clog2(LINE_MAXLEN);
  localparam logic [LEN_W-1:0] MAXLEN_L = LEN_W'(LINE_MAXLEN);
  localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

  line_state_t      state, state_nxt;
  logic [LEN_W-1:0] wr_cnt, rd_ptr, len_q, len_nxt, wr_cnt_eff;
  logic             trunc_q, trunc_nxt;
  logic             accept, is_bs, bs_dec, store, is_term, at_full;
  logic             close, rd_last;
  logic [7:0]       rd_data;

  assign accept  = app_out_valid_i & app_out_ready_o;
  assign is_term = (app_out_data_i == TERM_CHAR);
  assign at_full = ((wr_cnt + ONE_L) == MAXLEN_L);
  assign rd_last = (rd_ptr == (len_q - ONE_L));

`ifdef LINE_BUF_BS_EN
  assign is_bs = (app_out_data_i == BS_CHAR) || (app_out_data_i == DEL_CHAR);
`else
  assign is_bs = 1'b0;
`endif

  // A backspace is consumed but never stored; it only erases when there is
  // something to erase.
  assign store      = accept & ~is_bs;
  assign bs_dec     = accept & is_bs & (wr_cnt != '0);
  assign wr_cnt_eff = bs_dec ? (wr_cnt - ONE_L) : wr_cnt;

  // Line close decision and the length/trunc values latched with it. A byte
  // accepted together with a flush is stored first and counted in the line.
  always_comb begin
    close     = 1'b0;
    len_nxt   = wr_cnt + ONE_L;
    trunc_nxt = 1'b0;
    if (state == FILL) begin
      if (store) begin
        close     = is_term | at_full | flush_i;
        trunc_nxt = at_full & ~is_term;
      end else if (flush_i && (wr_cnt_eff != '0)) begin
        close   = 1'b1;
        len_nxt = wr_cnt_eff;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= FILL;
    else         state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    if (state == FILL) begin
      if (close) state_nxt = DRAIN;
    end else begin
      if (line_ready_i && rd_last) state_nxt = FILL;
    end
  end

  // Outputs; ready is held low while reset is asserted
  always_comb begin
    app_out_ready_o = rstn_i & (state == FILL);
    line_valid_o    = (state == DRAIN);
    line_last_o     = (state == DRAIN) & rd_last;
    line_len_o      = (state == DRAIN) ? len_q : '0;
    line_trunc_o    = (state == DRAIN) & trunc_q;
    line_data_o     = rd_data;
  end

  // Write count, read pointer and per-line framing info
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else if (state == FILL) begin
      if (store)       wr_cnt <= wr_cnt + ONE_L;
      else if (bs_dec) wr_cnt <= wr_cnt - ONE_L;
      if (close) begin
        len_q   <= len_nxt;
        trunc_q <= trunc_nxt;
      end
    end else if (line_ready_i) begin
      if (rd_last) begin
        rd_ptr <= '0;
        wr_cnt <= '0;
      end else begin
        rd_ptr <= rd_ptr + ONE_L;
      end
    end
  end

  line_buf_mem #(
    .DATA_W (8),
    .DEPTH  (LINE_MAXLEN),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (store),
    .waddr_i (wr_cnt[IDX_W-1:0]),
    .wdata_i (app_out_data_i),
    .raddr_i (rd_ptr[IDX_W-1:0]),
    .rdata_o (rd_data)
  );

endmodule
